// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the PIPE data-memory stage: icodes, FSM states, op decode.
package y86_pkg;

    localparam int unsigned DATA_W_DEF = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic is_mem;    // touches RAM
        logic is_wr;     // store (otherwise load)
        logic use_vala;  // address comes from valA (stack pop)
        logic wr_valp;   // store data comes from valP (return address)
    } op_t;

    function automatic op_t decode_op(input logic [3:0] icode);
        op_t op;
        op = '0;
        case (icode)
            I_RMMOVQ: begin op.is_mem = 1'b1; op.is_wr = 1'b1; end
            I_PUSHQ:  begin op.is_mem = 1'b1; op.is_wr = 1'b1; end
            I_CALL:   begin op.is_mem = 1'b1; op.is_wr = 1'b1; op.wr_valp = 1'b1; end
            I_MRMOVQ: begin op.is_mem = 1'b1; end
            I_RET:    begin op.is_mem = 1'b1; op.use_vala = 1'b1; end
            I_POPQ:   begin op.is_mem = 1'b1; op.use_vala = 1'b1; end
            I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_OPQ, I_JXX: op = '0;
            default:  op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-addressed RAM with one 8-byte little-endian combinational read port and a write port.
module dmem_ram #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_BYTES)-1:0] i_addr,
    input  logic [DATA_W-1:0]              i_wdata,
    output logic [DATA_W-1:0]              o_rdata_c
);
    localparam int unsigned AW    = $clog2(DEPTH_BYTES);
    localparam int unsigned LANES = DATA_W / 8;

    logic [7:0] r_mem [DEPTH_BYTES];

    // Lane k lives at addr+k, so byte 0 of the word is the lowest address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < int'(LANES); k++) begin
                r_mem[i_addr + AW'(k)] <= i_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        o_rdata_c = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            o_rdata_c[8*k +: 8] = r_mem[i_addr + AW'(k)];
        end
    end

endmodule

// File: rtl/y86_dmem_stage.sv
// Y86-64 PIPE data-memory stage: req/resp handshake, wait states, range/alignment errors.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module y86_dmem_stage
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valP,
    input  logic [DATA_W-1:0] valE,
    output logic              resp_valid,
    output logic [DATA_W-1:0] valM,
    output logic              mem_error,
    output logic              stall
);
    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = 4;
    localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(DEPTH_BYTES - 8);

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr, r_is_rd, r_err;
    logic              r_req_ready, r_resp_valid, r_mem_error, r_stall;
    logic [DATA_W-1:0] r_valM;

    op_t               w_in_op;
    logic [DATA_W-1:0] w_in_addr, w_in_wdata, w_rdata;
    logic              w_in_mis, w_in_err, w_accept, w_idle;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_is_wr, w_is_rd, w_err, w_we;

    // Decode and check the request presented at the input.
    assign w_in_op    = decode_op(icode);
    assign w_in_addr  = w_in_op.use_vala ? valA : valE;
    assign w_in_wdata = w_in_op.wr_valp  ? valP : valA;
`ifdef DMEM_ALIGN_CHECK_EN
    assign w_in_mis   = |w_in_addr[2:0];
`else
    assign w_in_mis   = 1'b0;
`endif
    assign w_in_err   = (w_in_addr > MAX_ADDR) | w_in_mis;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = req_valid & r_req_ready;

    // With zero wait states the access completes straight from IDLE, so bypass the latches.
    assign w_addr  = w_idle ? w_in_addr[AW-1:0] : r_addr;
    assign w_wdata = w_idle ? w_in_wdata : r_wdata;
    assign w_is_wr = w_idle ? (w_in_op.is_mem & w_in_op.is_wr)  : r_is_wr;
    assign w_is_rd = w_idle ? (w_in_op.is_mem & ~w_in_op.is_wr) : r_is_rd;
    assign w_err   = w_idle ? w_in_err : r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept && w_in_op.is_mem)
                         w_next = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (r_cnt <= CW'(1)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        w_we = (w_next == ST_DONE) & w_is_wr & ~w_err;
    end

    dmem_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .o_rdata_c (w_rdata)
    );

    // Request latch, wait counter and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_wr      <= 1'b0;
            r_is_rd      <= 1'b0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_valM       <= '0;
            r_mem_error  <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= (w_next == ST_IDLE);
            r_stall      <= (w_next != ST_IDLE);
            if (w_accept) begin
                r_addr  <= w_in_addr[AW-1:0];
                r_wdata <= w_in_wdata;
                r_is_wr <= w_in_op.is_mem & w_in_op.is_wr;
                r_is_rd <= w_in_op.is_mem & ~w_in_op.is_wr;
                r_err   <= w_in_err;
                r_cnt   <= CW'(WAIT_STATES);
            end else if (r_state == ST_WAIT) begin
                r_cnt   <= r_cnt - CW'(1);
            end
            if (w_next == ST_DONE) begin
                r_resp_valid <= 1'b1;
                r_mem_error  <= w_err;
                r_valM       <= (w_is_rd & ~w_err) ? w_rdata : '0;
            end else if (w_accept && !w_in_op.is_mem) begin
                r_resp_valid <= 1'b1;
                r_mem_error  <= 1'b0;
                r_valM       <= '0;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign valM       = r_valM;
    assign mem_error  = r_mem_error;
    assign stall      = r_stall;

endmodule

// File: tb/tb_y86_dmem_stage.sv
// Self-checking bench for y86_dmem_stage against a byte-array reference model.
module tb_y86_dmem_stage;
    localparam int unsigned WS    = 2;
    localparam int unsigned DEPTH = 1024;
    localparam int          BOUND = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  icode;
    logic [63:0] valA, valP, valE;
    logic        resp_valid;
    logic [63:0] valM;
    logic        mem_error;
    logic        stall;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic [63:0] last_valM;

    always #5 clk = ~clk;

    y86_dmem_stage #(
        .DATA_W      (64),
        .DEPTH_BYTES (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .icode      (icode),
        .valA       (valA),
        .valP       (valP),
        .valE       (valE),
        .resp_valid (resp_valid),
        .valM       (valM),
        .mem_error  (mem_error),
        .stall      (stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_is_mem(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    function automatic bit m_is_wr(input logic [3:0] ic);
        return ic inside {4'h4, 4'h8, 4'hA};
    endfunction

    function automatic bit m_err(input logic [63:0] ad);
        bit e;
        e = (ad > 64'(DEPTH - 8));
`ifdef DMEM_ALIGN_CHECK_EN
        if (ad % 8 != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [63:0] m_read(input logic [63:0] ad);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[int'(ad) + k];
        return r;
    endfunction

    task automatic m_write(input logic [63:0] ad, input logic [63:0] d);
        for (int k = 0; k < 8; k++) ref_mem[int'(ad) + k] = d[8*k +: 8];
    endtask

    task automatic scramble();
        icode = 4'($urandom);
        valA  = {$urandom, $urandom};
        valP  = {$urandom, $urandom};
        valE  = {$urandom, $urandom};
    endtask

    // One transaction: issue, wait for the response, check it against the model.
    task automatic do_req(input string tag, input logic [3:0] ic,
                          input logic [63:0] a, input logic [63:0] p, input logic [63:0] e);
        logic [63:0] ad, wd, exp_m;
        bit          mem, wr, err, seen;
        int          k, n;
        mem   = m_is_mem(ic);
        wr    = m_is_wr(ic);
        ad    = (ic == 4'h9 || ic == 4'hB) ? a : e;
        wd    = (ic == 4'h8) ? p : a;
        err   = mem && m_err(ad);
        exp_m = (mem && !wr && !err) ? m_read(ad) : 64'h0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        icode = ic; valA = a; valP = p; valE = e;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble();
        k = 0;
        seen = 1'b0;
        while (!seen && k < BOUND) begin
            @(negedge clk);
            k++;
            if (k == 1) chk({tag, ".stall"}, 64'(stall), 64'(mem));
            if (resp_valid) seen = 1'b1;
        end
        chk({tag, ".resp_seen"}, 64'(seen), 64'(1));
        chk({tag, ".latency"}, 64'(k), 64'(mem ? WS + 1 : 1));
        chk({tag, ".valM"}, valM, exp_m);
        chk({tag, ".mem_error"}, 64'(mem_error), 64'(err));
        if (mem && wr && !err) m_write(ad, wd);
        last_valM = exp_m;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ad, dat;
        logic [3:0]  ic;
        int          seen;
        rst_n = 1'b0;
        req_valid = 1'b0;
        icode = '0; valA = '0; valP = '0; valE = '0;
        last_valM = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready", 64'(req_ready), 64'(1));
        chk("rst.resp_valid", 64'(resp_valid), 64'(0));
        chk("rst.valM", valM, 64'h0);
        chk("rst.mem_error", 64'(mem_error), 64'(0));
        chk("rst.stall", 64'(stall), 64'(0));
        rst_n = 1'b1;

        // Give every RAM byte a known value.
        for (int i = 0; i < int'(DEPTH / 8); i++)
            do_req("fill", 4'h4, {$urandom, $urandom}, 64'h0, 64'(i * 8));

        do_req("rmmovq_10", 4'h4, 64'hAAAA5555, 64'h0, 64'h10);
        do_req("mrmovq_10", 4'h5, 64'h0, 64'h0, 64'h10);
        chk("mrmovq_10.val", last_valM, 64'hAAAA5555);
        @(negedge clk);
        chk("hold.resp_valid", 64'(resp_valid), 64'(0));
        chk("hold.valM", valM, last_valM);
        do_req("call", 4'h8, 64'h0, 64'h123, 64'h3F8);
        do_req("ret", 4'h9, 64'h3F8, 64'h0, 64'h0);
        do_req("pushq", 4'hA, 64'hDEADBEEF_CAFEF00D, 64'h0, 64'h200);
        do_req("popq", 4'hB, 64'h200, 64'h0, 64'h0);
        do_req("rd_3f9", 4'h5, 64'h0, 64'h0, 64'h3F9);
        do_req("wr_400", 4'h4, 64'h1111, 64'h0, 64'h400);
        do_req("rd_3f8", 4'h5, 64'h0, 64'h0, 64'h3F8);
        do_req("rd_hi64", 4'h5, 64'h0, 64'h0, 64'h1_0000_0010);
        do_req("rd_3f8_ok", 4'h5, 64'h0, 64'h0, 64'h3F8);
        do_req("halt", 4'h0, 64'h5, 64'h6, 64'h10);
        do_req("nop", 4'h1, 64'h5, 64'h6, 64'h10);
        do_req("wr_13", 4'h4, 64'h0102030405060708, 64'h0, 64'h13);
        do_req("rd_13", 4'h5, 64'h0, 64'h0, 64'h13);
        do_req("rd_10_after13", 4'h5, 64'h0, 64'h0, 64'h10);

        // Reset during the WAIT of a store: nothing committed, no response.
        @(negedge clk);
        req_valid = 1'b1; icode = 4'h4; valA = 64'h5A5A_0000_1234; valP = '0; valE = 64'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.req_ready", 64'(req_ready), 64'(1));
        chk("midrst.resp_valid", 64'(resp_valid), 64'(0));
        chk("midrst.stall", 64'(stall), 64'(0));
        chk("midrst.valM", valM, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("midrst.no_resp", 64'(seen), 64'(0));
        do_req("midrst.rd_20", 4'h5, 64'h0, 64'h0, 64'h20);

        // Random traffic across all icodes and address classes.
        for (int i = 0; i < 80; i++) begin
            ic  = 4'($urandom_range(0, 15));
            dat = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                6:       ad = 64'($urandom_range(DEPTH - 7, DEPTH + 64));
                7:       ad = {$urandom, $urandom};
                default: ad = 64'($urandom_range(0, DEPTH - 8));
            endcase
            if (ic == 4'h9 || ic == 4'hB)
                do_req("rand", ic, ad, {$urandom, $urandom}, {$urandom, $urandom});
            else
                do_req("rand", ic, dat, {$urandom, $urandom}, ad);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
